// File: rtl/param_shift_engine.sv
// param_shift_engine: parametrised load / rotate / shift register.
// Performs a programmed number of single-bit shifts, one per clock.
module param_shift_engine #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load_n,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] M_ROR = 2'b00;
  localparam logic [1:0] M_ROL = 2'b01;
  localparam logic [1:0] M_LSL = 2'b10;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [1:0]         mode_q,  mode_d;
  logic [SHAMT_W-1:0] cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  function automatic logic [WIDTH-1:0] shift1(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_LSL:   r = {v[WIDTH-2:0], 1'b0};
      default: r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // Next-state: load/start arbitration in IDLE, one shift per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!load_n) begin
          data_d = data_in;
        end else if (start) begin
          if (shamt != '0) begin
            mode_d  = mode;
            cnt_d   = shamt;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        data_d = shift1(mode_q, data_q);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset dominates everything.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// tb_param_shift_engine: directed bench with an operation-level
// reference model compared against the DUT every cycle.
module tb_param_shift_engine;

  localparam int W = 8;
  localparam int S = 4;

  logic         clock;
  logic         reset_n;
  logic         load_n;
  logic [W-1:0] data_in;
  logic         start;
  logic [1:0]   mode;
  logic [S-1:0] shamt;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int tests;
  int fails;

  param_shift_engine #(.WIDTH(W), .SHAMT_W(S)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .load_n  (load_n),
    .data_in (data_in),
    .start   (start),
    .mode    (mode),
    .shamt   (shamt),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Closed-form result of k shifts of v in mode m.
  function automatic logic [W-1:0] apply(
    input logic [W-1:0] v,
    input logic [1:0]   m,
    input int           k
  );
    int r;
    logic [2*W-1:0] d;
    logic [W-1:0] res;
    r = k % W;
    d = {v, v};
    case (m)
      2'd0: res = W'(d >> r);
      2'd1: res = W'(d >> ((W - r) % W));
      2'd2: res = (k >= W) ? '0 : W'(v << k);
      default: res = (k >= W) ? {W{v[W-1]}}
                              : W'($signed(v) >>> k);
    endcase
    return res;
  endfunction

  // Reference model: tracks whole operations, not shift registers.
  logic [W-1:0] m_q;
  logic         m_busy;
  logic         m_done;
  bit           act;
  logic [W-1:0] op_v;
  logic [1:0]   op_m;
  int           op_n;
  int           op_k;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_q = '0; m_busy = 0; m_done = 0; act = 0;
    end else begin
      m_done = 0;
      if (act) begin
        op_k = op_k + 1;
        m_q = apply(op_v, op_m, op_k);
        if (op_k == op_n) begin
          act = 0; m_busy = 0; m_done = 1;
        end
      end else if (!load_n) begin
        m_q = data_in;
      end else if (start) begin
        if (shamt == '0) m_done = 1;
        else begin
          act = 1; m_busy = 1;
          op_v = m_q; op_m = mode;
          op_n = int'(shamt); op_k = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  // One clock; then compare DUT against the model away from the edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_n = 0; data_in = v;
    tick();
    load_n = 1;
  endtask

  // Start an op, run to done; report busy cycles and done pulses seen.
  task automatic run_op(input logic [1:0] m, input logic [S-1:0] n,
                        output int bc, output int dc);
    int guard;
    start = 1; mode = m; shamt = n;
    tick();
    start = 0;
    bc = busy ? 1 : 0;
    dc = done ? 1 : 0;
    guard = 0;
    while (!done && guard < 40) begin
      tick();
      guard++;
      if (busy) bc++;
      if (done) dc++;
    end
    if (guard >= 40) chk("op_timeout", 1, 0);
  endtask

  int bc, dc;

  initial begin
    tests = 0; fails = 0;
    reset_n = 0; load_n = 1; data_in = '0;
    start = 0; mode = '0; shamt = '0;
    @(negedge clock);

    // 1: reset then load
    tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset_n = 1;
    do_load(8'hA5);
    chk("load_q", 32'(q), 32'hA5);
    chk("load_busy", 32'(busy), 0);

    // 2: ROR by 3, edge by edge
    start = 1; mode = 2'd0; shamt = 4'd3;
    tick();
    start = 0;
    chk("t2_e0_q", 32'(q), 32'hA5);
    chk("t2_e0_busy", 32'(busy), 1);
    tick();
    chk("t2_e1_q", 32'(q), 32'hD2);
    tick();
    chk("t2_e2_q", 32'(q), 32'h69);
    chk("t2_e2_busy", 32'(busy), 1);
    tick();
    chk("t2_e3_q", 32'(q), 32'hB4);
    chk("t2_e3_busy", 32'(busy), 0);
    chk("t2_e3_done", 32'(done), 1);
    tick();
    chk("t2_e4_done", 32'(done), 0);

    // 3: ASR, LSL, ROL wrap
    do_load(8'h80);
    run_op(2'd3, 4'd3, bc, dc);
    chk("asr_q", 32'(q), 32'hF0);
    chk("asr_busy_cyc", 32'(bc), 3);
    do_load(8'h81);
    run_op(2'd2, 4'd1, bc, dc);
    chk("lsl_q", 32'(q), 32'h02);
    do_load(8'h81);
    run_op(2'd1, 4'd9, bc, dc);
    chk("rol9_q", 32'(q), 32'h03);
    chk("rol9_busy_cyc", 32'(bc), 9);
    do_load(8'h81);
    run_op(2'd2, 4'd12, bc, dc);
    chk("lsl_sat_q", 32'(q), 32'h00);
    do_load(8'h96);
    run_op(2'd3, 4'd15, bc, dc);
    chk("asr_sat_q", 32'(q), 32'hFF);

    // 4: zero shift count; load beats start
    do_load(8'h5A);
    start = 1; mode = 2'd0; shamt = 4'd0;
    tick();
    start = 0;
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    chk("z_q", 32'(q), 32'h5A);
    tick();
    chk("z_done_clr", 32'(done), 0);
    load_n = 0; data_in = 8'h3C; start = 1; shamt = 4'd2;
    tick();
    load_n = 1; start = 0;
    chk("ls_q", 32'(q), 32'h3C);
    chk("ls_busy", 32'(busy), 0);
    tick();
    chk("ls_done", 32'(done), 0);

    // 5: disturbances ignored mid-op, back-to-back start
    do_load(8'hA5);
    start = 1; mode = 2'd0; shamt = 4'd5;
    tick();
    start = 0;
    tick();
    start = 1; load_n = 0; data_in = 8'h00;
    mode = 2'd2; shamt = 4'd1;
    tick();
    start = 0; load_n = 1;
    bc = 3; dc = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (busy) bc++;
      if (done) dc++;
    end
    chk("dist_q", 32'(q), 32'h2D);
    chk("dist_busy_cyc", 32'(bc), 5);
    chk("dist_done_cnt", 32'(dc), 1);
    start = 1; mode = 2'd1; shamt = 4'd2;
    tick();
    start = 0;
    chk("b2b_busy", 32'(busy), 1);
    tick();
    tick();
    chk("b2b_q", 32'(q), 32'hB4);
    chk("b2b_done", 32'(done), 1);

    // 6: reset aborts a running op
    tick();
    do_load(8'h01);
    start = 1; mode = 2'd0; shamt = 4'd7;
    tick();
    start = 0;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("abort_q", 32'(q), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dc++;
    end
    chk("abort_no_done", 32'(dc), 0);
    do_load(8'h0F);
    run_op(2'd2, 4'd4, bc, dc);
    chk("post_q", 32'(q), 32'hF0);
    chk("post_done", 32'(dc), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_shift_engine.md
Name: param_shift_engine

Overview:
- Parametrised, multi-mode shift register. Performs a programmed number of single-bit shifts, one per clock, under a start/busy/done handshake.
- Generalises the team's fixed 8-bit load/rotate/arithmetic-shift register:
  - WIDTH is a parameter.
  - Four shift modes.
  - Shift count is multi-cycle and programmable.
- Sits between switch/key input logic and LED/datapath consumers.

Parameters:
- WIDTH, 8, data/register width in bits (minimum 2).
- SHAMT_W, 4, width of the shift-amount input. Maximum shift count is 2^SHAMT_W-1.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous reset, active-low
- load_n  input  1  parallel load strobe, active-low
- data_in  input  WIDTH  parallel load data
- start  input  1  begin a shift operation, active-high
- mode  input  2  shift mode: 00 ROR, 01 ROL, 10 LSL, 11 ASR
- shamt  input  SHAMT_W  number of single-bit shifts to perform
- q  output  WIDTH  register contents
- busy  output  1  high while shifts are in progress
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset and clock (already decided): reset reset_n, synchronous, active-low; clock clock.
- Reset sampled low at a clock edge:
  - q=0, busy=0, done=0, state=IDLE, internal count=0.
  - Reset has priority over every other input, including mid-operation.
- State machine has two states, IDLE and SHIFT. done is a registered pulse, not a state.
- done defaults to 0 every cycle unless explicitly set below.
- IDLE, priority order:
  1. load_n=0: q<=data_in. busy stays 0. start is ignored that cycle.
  2. Else start=1 with shamt!=0:
     - Latch mode and shamt into internal registers.
     - busy<=1, count<=shamt, go to SHIFT.
     - q is unchanged at this edge.
  3. Else start=1 with shamt=0: done<=1 for one cycle, q unchanged, stay in IDLE, busy never asserts.
  4. Else: hold q.
- SHIFT: each edge performs one shift using the latched mode.
  - ROR: q <= {q[0], q[WIDTH-1:1]}
  - ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - LSL: q <= {q[WIDTH-2:0], 1'b0}
  - ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]} (sign bit preserved)
  - count decrements by 1 per shift.
  - On the shift where count==1: busy<=0, done<=1, return to IDLE.
- Latency:
  - start sampled at edge E0; shifts occur at edges E1..EN.
  - After EN: busy=0, done=1. After EN+1: done=0.
  - busy is high for exactly N cycles.
- While busy=1:
  - start and load_n are ignored.
  - Changes on mode/shamt/data_in do not affect the operation in progress.
- Back-to-back: start is accepted in the IDLE cycle in which done=1. The new operation begins with no dead cycle.
- Shift counts >= WIDTH are legal:
  - Rotates wrap modulo WIDTH.
  - LSL saturates to 0.
  - ASR saturates to all sign bits.
- Reset asserted during SHIFT aborts the operation: no done pulse, q=0.
- No combinational paths from inputs to outputs. All outputs are registered.

Test Plan:
1. WIDTH=8. reset_n=0 for one edge, then load_n=0 with data_in=0xA5 -> q=0x00 after the reset edge, q=0xA5 after the load edge, busy=0, done=0.
2. q=0xA5, start=1, mode=00, shamt=3 -> q=0xD2, 0x69, 0xB4 on edges E1..E3. busy=1 for exactly 3 cycles. done=1 for one cycle after E3.
3. Load 0x80, start mode=11, shamt=3 -> q=0xF0. Load 0x81, mode=10, shamt=1 -> q=0x02. Load 0x81, mode=01, shamt=9 -> q=0x03 after 9 busy cycles.
4. start with shamt=0 on q=0x5A -> done=1 one cycle after start, busy never asserted, q=0x5A. Repeat with load_n=0 and start=1 in the same cycle -> load wins, q=data_in, no done pulse.
5. During a mode=00, shamt=5 operation, pulse start=1, load_n=0 and change mode/shamt at cycle 2 -> all ignored, exactly 5 ROR shifts, single done pulse. Issue a new start in the done cycle -> busy rises on the next edge.
6. Assert reset_n=0 at cycle 2 of a shamt=7 operation -> next edge gives q=0, busy=0, done=0, with no later done pulse. A subsequent load+start completes normally.
